serial_adder: RTL and testbench

Bit-serial ripple adder: one full-adder cell plus a carry flip-flop produces an N-bit sum LSB-first, one bit per clock. It is the additive counterpart of the combinational full-subtractor cell. It serves area-constrained datapaths that can trade latency for gates, and it is the reference model for the later serial add/subtract unit. Operands are captured on a start handshake; results are presented with a one-cycle done pulse.

---
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop produce the sum LSB-first,
// one bit per clock, with a start/done handshake around each operation.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic s_bit;
    logic c_next;

    assign s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign c_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            work_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            work_q  <= work_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        work_d  = work_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                // Each new bit enters at the MSB so the last bit lands the word aligned.
                work_d = {s_bit, work_q[WIDTH-1:1]};
                c_d    = c_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = work_d;
                    cout_d  = c_next;
                    ovf_d   = c_q ^ c_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 3-bit instance checked every cycle against
// an arithmetic timeline model, plus directed literal cases.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st8 = 1'b0, ci8 = 1'b0, st3 = 1'b0, ci3 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [2:0] a3 = '0, b3 = '0;
    logic [1:0] busy_w, done_w, cout_w, ovf_w;
    logic [7:0] sum8;
    logic [2:0] sum3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum8), .cout(cout_w[0]), .ovf(ovf_w[0])
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .a(a3), .b(b3), .cin(ci3),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum3), .cout(cout_w[1]), .ovf(ovf_w[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: cycles since acceptance (-1 when idle) plus the arithmetic result.
    int m_t [2] = '{-1, -1};
    int ma [2], mb [2], mc [2];
    int m_sum [2] = '{0, 0};
    int m_cout [2] = '{0, 0};
    int m_ovf [2] = '{0, 0};

    function automatic int wd(input int k);
        return (k == 0) ? 8 : 3;
    endfunction

    function automatic int res_sum(input int x, input int y, input int c, input int w);
        return (x + y + c) % (1 << w);
    endfunction

    function automatic int res_cout(input int x, input int y, input int c, input int w);
        return (x + y + c) >= (1 << w) ? 1 : 0;
    endfunction

    function automatic int res_ovf(input int x, input int y, input int c, input int w);
        int sx, sy, ss;
        sx = (x >> (w - 1)) & 1;
        sy = (y >> (w - 1)) & 1;
        ss = (res_sum(x, y, c, w) >> (w - 1)) & 1;
        return (sx == sy && ss != sx) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_t[k]    <= -1;
                m_sum[k]  <= 0;
                m_cout[k] <= 0;
                m_ovf[k]  <= 0;
            end else if (m_t[k] < 0) begin
                if ((k == 0) ? st8 : st3) begin
                    ma[k]  <= (k == 0) ? int'(a8) : int'(a3);
                    mb[k]  <= (k == 0) ? int'(b8) : int'(b3);
                    mc[k]  <= (k == 0) ? int'(ci8) : int'(ci3);
                    m_t[k] <= 0;
                end
            end else if (m_t[k] == wd(k)) begin
                m_t[k] <= -1;
            end else begin
                m_t[k] <= m_t[k] + 1;
                if (m_t[k] + 1 == wd(k)) begin
                    m_sum[k]  <= res_sum(ma[k], mb[k], mc[k], wd(k));
                    m_cout[k] <= res_cout(ma[k], mb[k], mc[k], wd(k));
                    m_ovf[k]  <= res_ovf(ma[k], mb[k], mc[k], wd(k));
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy[%0d]", k), busy_w[k], (m_t[k] >= 0 && m_t[k] < wd(k)) ? 1 : 0);
            chk($sformatf("done[%0d]", k), done_w[k], (m_t[k] == wd(k)) ? 1 : 0);
            chk($sformatf("cout[%0d]", k), cout_w[k], m_cout[k]);
            chk($sformatf("ovf[%0d]", k), ovf_w[k], m_ovf[k]);
        end
        chk("sum8", sum8, m_sum[0]);
        chk("sum3", sum3, m_sum[1]);
    end

    // Inputs move 2 time units after the falling edge, clear of both edges.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_op(input int k, input int x, input int y, input int c, output int lat);
        tick();
        if (k == 0) begin
            st8 = 1'b1; a8 = 8'(x); b8 = 8'(y); ci8 = c[0];
        end else begin
            st3 = 1'b1; a3 = 3'(x); b3 = 3'(y); ci3 = c[0];
        end
        tick();
        st8 = 1'b0; st3 = 1'b0;
        // Post-capture operand changes must not disturb the result.
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
        a3 = 3'($urandom); b3 = 3'($urandom); ci3 = 1'($urandom);
        lat = 0;
        while (!done_w[k] && lat < 40) begin
            tick();
            lat++;
        end
        if (lat >= 40) begin
            errors++;
            $display("FAIL timeout[%0d] actual=no done required=done", k);
        end
    endtask

    task automatic lit8(input string nm, input int x, input int y, input int c,
                        input int es, input int ec, input int eo);
        int lat;
        do_op(0, x, y, c, lat);
        chk({nm, ".lat"}, lat, 8);
        chk({nm, ".sum"}, sum8, es);
        chk({nm, ".cout"}, cout_w[0], ec);
        chk({nm, ".ovf"}, ovf_w[0], eo);
        chk({nm, ".model"}, m_sum[0], es);
    endtask

    initial begin
        int lat;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("rst.sum8", sum8, 0);
        chk("rst.busy8", busy_w[0], 0);

        lit8("basic", 8'h3C, 8'h15, 0, 8'h51, 0, 0);
        lit8("ff+01", 8'hFF, 8'h01, 0, 8'h00, 1, 0);
        lit8("7f+01", 8'h7F, 8'h01, 0, 8'h80, 0, 1);
        lit8("80+80", 8'h80, 8'h80, 0, 8'h00, 1, 1);
        lit8("ff+ff+1", 8'hFF, 8'hFF, 1, 8'hFF, 1, 0);
        lit8("00+00+1", 8'h00, 8'h00, 1, 8'h01, 0, 0);

        // Asynchronous reset between edges clears outputs at once.
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst.sum8", sum8, 0);
        chk("arst.cout8", cout_w[0], 0);
        chk("arst.ovf8", ovf_w[0], 0);
        tick();
        rst_n = 1'b1;

        // Start held high with operands changing every cycle.
        tick();
        st8 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            tick();
        end
        st8 = 1'b0;
        repeat (12) tick();

        // Abort mid-operation at bit 4.
        tick();
        st8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0;
        tick();
        st8 = 1'b0;
        repeat (4) tick();
        chk("abort.busy_before", busy_w[0], 1);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", busy_w[0], 0);
        chk("abort.done", done_w[0], 0);
        chk("abort.sum8", sum8, 0);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        lit8("01+02", 8'h01, 8'h02, 0, 8'h03, 0, 0);

        for (int i = 0; i < 150; i++)
            do_op(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), lat);

        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                for (int c = 0; c < 2; c++) begin
                    do_op(1, x, y, c, lat);
                    chk("w3.sum", sum3, (x + y + c) & 7);
                    chk("w3.cout", cout_w[1], (x + y + c) >> 3);
                end

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
